// File: rtl/frame_feeder.sv
// Packs accepted upstream samples into THROUGHPUT-wide words with frame markers,
// forcing an idle gap of GAP_CYCLES after each completed or aborted frame.
//
// state | meaning
// FILL  | accepting samples (in_rdy high from the register)
// GAP   | post-frame idle, in_rdy low for GAP_CYCLES cycles
module frame_feeder #(
   parameter int NO_CH         = 16,
   parameter int LOG2_IMG_SIZE = 10,
   parameter int THROUGHPUT    = 1,
   parameter int GAP_CYCLES    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [NO_CH-1:0] in_data,
   output logic             in_rdy,
   input  logic             frame_abort,
   output logic             vld_out,
   output logic [NO_CH-1:0] data_out [THROUGHPUT-1:0],
   output logic             sof_out,
   output logic             eof_out,
   output logic [15:0]      frames_done
);

   localparam logic [LOG2_IMG_SIZE-1:0] LANE_MASK = LOG2_IMG_SIZE'(THROUGHPUT - 1);
   localparam logic [LOG2_IMG_SIZE-1:0] IDX_LAST  = '1;
   localparam logic [7:0]               GAP_LOAD  = 8'(GAP_CYCLES);

   typedef enum logic {FILL, GAP} state_t;

   state_t                   state;
   logic [7:0]               gap_cnt;
   logic [LOG2_IMG_SIZE-1:0] idx;
   logic [NO_CH-1:0]         staged [THROUGHPUT-1:0];
   logic                     accept;
   logic                     grp_last;
   logic                     frm_last;

   assign accept   = in_vld && in_rdy;
   // Lane position is the low bits of the sample index, since frames hold whole groups.
   assign grp_last = (idx & LANE_MASK) == LANE_MASK;
   assign frm_last = idx == IDX_LAST;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= FILL;
         gap_cnt <= '0;
         in_rdy  <= 1'b0;
      end else if (frame_abort) begin
         state   <= (GAP_CYCLES == 0) ? FILL : GAP;
         gap_cnt <= GAP_LOAD;
         in_rdy  <= (GAP_CYCLES == 0);
      end else begin
         case (state)
            FILL: begin
               if (accept && frm_last && (GAP_CYCLES != 0)) begin
                  state   <= GAP;
                  gap_cnt <= GAP_LOAD;
                  in_rdy  <= 1'b0;
               end else begin
                  in_rdy <= 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt <= 8'd1) begin
                  state  <= FILL;
                  in_rdy <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            default: begin
               state  <= FILL;
               in_rdy <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx         <= '0;
         vld_out     <= 1'b0;
         sof_out     <= 1'b0;
         eof_out     <= 1'b0;
         frames_done <= '0;
         for (int k = 0; k < THROUGHPUT; k++) begin
            staged[k]   <= '0;
            data_out[k] <= '0;
         end
      end else begin
         vld_out <= 1'b0;
         sof_out <= 1'b0;
         eof_out <= 1'b0;
         if (frame_abort) begin
            // Abort wins over a same-edge accept: that sample is dropped.
            idx <= '0;
            for (int k = 0; k < THROUGHPUT; k++) begin
               staged[k] <= '0;
            end
         end else if (accept) begin
            idx <= idx + LOG2_IMG_SIZE'(1);
            for (int k = 0; k < THROUGHPUT; k++) begin
               if ((idx & LANE_MASK) == LOG2_IMG_SIZE'(k)) begin
                  staged[k] <= in_data;
               end
            end
            if (grp_last) begin
               vld_out <= 1'b1;
               sof_out <= (idx == LANE_MASK);
               eof_out <= frm_last;
               for (int k = 0; k < THROUGHPUT; k++) begin
                  data_out[k] <= (k == THROUGHPUT - 1) ? in_data : staged[k];
               end
            end
            if (frm_last) begin
               frames_done <= frames_done + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_feeder.sv
// Drives four frame_feeder configurations with shared stimulus and checks each
// against a sample-queue model; directed scenarios pin the model with literals.
module tb_frame_feeder;

   localparam int TPC [4] = '{1, 2, 1, 4};
   localparam int NC  [4] = '{8, 8, 8, 16};
   localparam int GC  [4] = '{2, 2, 0, 3};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_vld = 1'b0;
   logic [15:0] in_data = '0;
   logic        frame_abort = 1'b0;

   logic        rdy0, rdy1, rdy2, rdy3;
   logic        vld0, vld1, vld2, vld3;
   logic        sof0, sof1, sof2, sof3;
   logic        eof0, eof1, eof2, eof3;
   logic [15:0] frm0, frm1, frm2, frm3;
   logic [15:0] dat0 [0:0];
   logic [15:0] dat1 [1:0];
   logic [15:0] dat2 [0:0];
   logic [15:0] dat3 [3:0];

   always #5 clk = ~clk;

   frame_feeder #(.NO_CH(16), .LOG2_IMG_SIZE(3), .THROUGHPUT(1), .GAP_CYCLES(2)) u_d0 (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(rdy0),
      .frame_abort(frame_abort), .vld_out(vld0), .data_out(dat0), .sof_out(sof0),
      .eof_out(eof0), .frames_done(frm0));
   frame_feeder #(.NO_CH(16), .LOG2_IMG_SIZE(3), .THROUGHPUT(2), .GAP_CYCLES(2)) u_d1 (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(rdy1),
      .frame_abort(frame_abort), .vld_out(vld1), .data_out(dat1), .sof_out(sof1),
      .eof_out(eof1), .frames_done(frm1));
   frame_feeder #(.NO_CH(16), .LOG2_IMG_SIZE(3), .THROUGHPUT(1), .GAP_CYCLES(0)) u_d2 (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(rdy2),
      .frame_abort(frame_abort), .vld_out(vld2), .data_out(dat2), .sof_out(sof2),
      .eof_out(eof2), .frames_done(frm2));
   frame_feeder #(.NO_CH(16), .LOG2_IMG_SIZE(4), .THROUGHPUT(4), .GAP_CYCLES(3)) u_d3 (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(rdy3),
      .frame_abort(frame_abort), .vld_out(vld3), .data_out(dat3), .sof_out(sof3),
      .eof_out(eof3), .frames_done(frm3));

   logic        obs_vld [4];
   logic        obs_sof [4];
   logic        obs_eof [4];
   logic        obs_rdy [4];
   logic [15:0] obs_frm [4];
   logic [15:0] obs_data [4][4];

   always_comb begin
      for (int d = 0; d < 4; d++) begin
         for (int l = 0; l < 4; l++) obs_data[d][l] = '0;
      end
      obs_vld = '{vld0, vld1, vld2, vld3};
      obs_sof = '{sof0, sof1, sof2, sof3};
      obs_eof = '{eof0, eof1, eof2, eof3};
      obs_rdy = '{rdy0, rdy1, rdy2, rdy3};
      obs_frm = '{frm0, frm1, frm2, frm3};
      obs_data[0][0] = dat0[0];
      obs_data[1][0] = dat1[0];
      obs_data[1][1] = dat1[1];
      obs_data[2][0] = dat2[0];
      for (int l = 0; l < 4; l++) obs_data[3][l] = dat3[l];
   end

   // Reference model: a sample counter per frame, a list of staged samples,
   // and the first cycle number at which the feeder may accept again.
   int          cyc = 0;
   int          m_cnt [4];
   int          m_gl [4];
   int          m_ready_at [4];
   logic [15:0] m_grp [4][4];
   logic        e_vld [4];
   logic        e_sof [4];
   logic        e_eof [4];
   logic [15:0] e_frm [4];
   logic [15:0] e_data [4][4];
   logic        m_rdy;

   always @(posedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (rst) begin
            m_cnt[d] = 0;
            m_gl[d] = 0;
            m_ready_at[d] = cyc + 2;
            e_vld[d] = 1'b0;
            e_sof[d] = 1'b0;
            e_eof[d] = 1'b0;
            e_frm[d] = '0;
            for (int l = 0; l < 4; l++) e_data[d][l] = '0;
         end else begin
            m_rdy = (cyc >= m_ready_at[d]);
            e_vld[d] = 1'b0;
            e_sof[d] = 1'b0;
            e_eof[d] = 1'b0;
            if (frame_abort) begin
               m_cnt[d] = 0;
               m_gl[d] = 0;
               m_ready_at[d] = cyc + 1 + GC[d];
            end else if (in_vld && m_rdy) begin
               m_grp[d][m_gl[d]] = in_data;
               m_gl[d]++;
               m_cnt[d]++;
               if (m_gl[d] == TPC[d]) begin
                  e_vld[d] = 1'b1;
                  e_sof[d] = (m_cnt[d] == TPC[d]);
                  e_eof[d] = (m_cnt[d] == NC[d]);
                  for (int l = 0; l < TPC[d]; l++) e_data[d][l] = m_grp[d][l];
                  m_gl[d] = 0;
               end
               if (m_cnt[d] == NC[d]) begin
                  m_cnt[d] = 0;
                  e_frm[d] = e_frm[d] + 16'd1;
                  m_ready_at[d] = cyc + 1 + GC[d];
               end
            end
         end
      end
      cyc++;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d cyc%0d: got %0h expected %0h", nm, d, cyc, act, exp);
      end
   endtask

   int          log_n [4] = '{0, 0, 0, 0};
   int          low_n [4] = '{0, 0, 0, 0};
   logic [15:0] log_l0 [4][256];
   logic [15:0] log_l1 [4][256];
   logic        log_sof [4][256];
   logic        log_eof [4][256];

   always @(negedge clk) begin
      if (cyc > 0) begin
         for (int d = 0; d < 4; d++) begin
            if (rst) begin
               chk("rst_rdy", d, 32'(obs_rdy[d]), 32'd0);
               chk("rst_vld", d, 32'(obs_vld[d]), 32'd0);
               chk("rst_sof", d, 32'(obs_sof[d]), 32'd0);
               chk("rst_eof", d, 32'(obs_eof[d]), 32'd0);
               chk("rst_frames", d, 32'(obs_frm[d]), 32'd0);
               for (int l = 0; l < TPC[d]; l++) chk("rst_data", d, 32'(obs_data[d][l]), 32'd0);
            end else begin
               chk("in_rdy", d, 32'(obs_rdy[d]), 32'(cyc >= m_ready_at[d]));
               chk("vld_out", d, 32'(obs_vld[d]), 32'(e_vld[d]));
               chk("sof_out", d, 32'(obs_sof[d]), 32'(e_sof[d]));
               chk("eof_out", d, 32'(obs_eof[d]), 32'(e_eof[d]));
               chk("frames_done", d, 32'(obs_frm[d]), 32'(e_frm[d]));
               for (int l = 0; l < TPC[d]; l++) chk("data_out", d, 32'(obs_data[d][l]), 32'(e_data[d][l]));
               if (obs_vld[d]) begin
                  log_l0[d][log_n[d] % 256] = obs_data[d][0];
                  log_l1[d][log_n[d] % 256] = obs_data[d][1];
                  log_sof[d][log_n[d] % 256] = obs_sof[d];
                  log_eof[d][log_n[d] % 256] = obs_eof[d];
                  log_n[d]++;
               end
               if (!obs_rdy[d]) low_n[d]++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] dt, input logic ab);
      in_vld = v;
      in_data = dt;
      frame_abort = ab;
   endtask

   task automatic flush_abort();
      drive(1'b0, 16'h0, 1'b1);
      step();
      drive(1'b0, 16'h0, 1'b0);
      repeat (3) step();
   endtask

   int base0, base1, base2, low0, low2, rst_hold;

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      step();

      // Frame of 1..8 with in_vld held high
      base0 = log_n[0]; base1 = log_n[1]; low0 = low_n[0];
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 16'(i), 1'b0);
         step();
      end
      drive(1'b0, 16'h0, 1'b0);
      repeat (6) step();
      chk("t1_d0_pulses", 0, 32'(log_n[0] - base0), 32'd8);
      for (int i = 0; i < 8; i++) chk("t1_d0_data", 0, 32'(log_l0[0][(base0 + i) % 256]), 32'(i + 1));
      chk("t1_d0_sof_first", 0, 32'(log_sof[0][base0 % 256]), 32'd1);
      chk("t1_d0_sof_second", 0, 32'(log_sof[0][(base0 + 1) % 256]), 32'd0);
      chk("t1_d0_eof_last", 0, 32'(log_eof[0][(base0 + 7) % 256]), 32'd1);
      chk("t1_d0_eof_prev", 0, 32'(log_eof[0][(base0 + 6) % 256]), 32'd0);
      chk("t1_d0_rdy_low", 0, 32'(low_n[0] - low0), 32'd2);
      chk("t1_d0_frames", 0, 32'(frm0), 32'd1);
      chk("t2_d1_pulses", 1, 32'(log_n[1] - base1), 32'd4);
      for (int j = 0; j < 4; j++) begin
         chk("t2_d1_lane0", 1, 32'(log_l0[1][(base1 + j) % 256]), 32'(2 * j + 1));
         chk("t2_d1_lane1", 1, 32'(log_l1[1][(base1 + j) % 256]), 32'(2 * j + 2));
      end
      chk("t2_d1_sof", 1, 32'(log_sof[1][base1 % 256]), 32'd1);
      chk("t2_d1_eof", 1, 32'(log_eof[1][(base1 + 3) % 256]), 32'd1);

      // in_vld toggling mid-group only stalls
      base1 = log_n[1];
      drive(1'b1, 16'h00A1, 1'b0);
      step();
      drive(1'b0, 16'hDEAD, 1'b0);
      step();
      chk("t3_hold_vld", 1, 32'(vld1), 32'd0);
      chk("t3_hold_l0", 1, 32'(dat1[0]), 32'd7);
      chk("t3_hold_l1", 1, 32'(dat1[1]), 32'd8);
      drive(1'b1, 16'h00B2, 1'b0);
      step();
      chk("t3_pulse", 1, 32'(vld1), 32'd1);
      chk("t3_l0", 1, 32'(dat1[0]), 32'h00A1);
      chk("t3_l1", 1, 32'(dat1[1]), 32'h00B2);
      drive(1'b0, 16'h0, 1'b0);
      step();
      chk("t3_pulse_count", 1, 32'(log_n[1] - base1), 32'd1);

      // Abort on the edge accepting sample 5
      flush_abort();
      base0 = log_n[0];
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'(16'h11 + i), 1'b0);
         step();
      end
      drive(1'b1, 16'h0015, 1'b1);
      step();
      drive(1'b0, 16'h0, 1'b0);
      chk("t4_rdy_gap1", 0, 32'(rdy0), 32'd0);
      step();
      chk("t4_rdy_gap2", 0, 32'(rdy0), 32'd0);
      step();
      chk("t4_rdy_back", 0, 32'(rdy0), 32'd1);
      chk("t4_pulses", 0, 32'(log_n[0] - base0), 32'd4);
      chk("t4_last_data", 0, 32'(log_l0[0][(base0 + 3) % 256]), 32'h0014);
      chk("t4_frames", 0, 32'(frm0), 32'd1);
      drive(1'b1, 16'h0055, 1'b0);
      step();
      drive(1'b0, 16'h0, 1'b0);
      chk("t4_next_vld", 0, 32'(vld0), 32'd1);
      chk("t4_next_sof", 0, 32'(sof0), 32'd1);
      chk("t4_next_data", 0, 32'(dat0[0]), 32'h0055);

      // GAP_CYCLES = 0: two frames back to back
      flush_abort();
      base2 = log_n[2]; low2 = low_n[2];
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 16'(16'h100 + i), 1'b0);
         step();
      end
      drive(1'b0, 16'h0, 1'b0);
      step();
      chk("t5_pulses", 2, 32'(log_n[2] - base2), 32'd16);
      chk("t5_rdy_low", 2, 32'(low_n[2] - low2), 32'd0);
      chk("t5_frames", 2, 32'(frm2), 32'd3);
      chk("t5_eof8", 2, 32'(log_eof[2][(base2 + 7) % 256]), 32'd1);
      chk("t5_sof9", 2, 32'(log_sof[2][(base2 + 8) % 256]), 32'd1);

      // Reset after 3 of 8 samples
      flush_abort();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'(16'h31 + i), 1'b0);
         step();
      end
      drive(1'b0, 16'h0, 1'b0);
      rst = 1'b1;
      #1;
      chk("t6_vld", 0, 32'(vld0), 32'd0);
      chk("t6_rdy", 0, 32'(rdy0), 32'd0);
      chk("t6_frames", 0, 32'(frm0), 32'd0);
      chk("t6_data", 0, 32'(dat0[0]), 32'd0);
      chk("t6_d1_l1", 1, 32'(dat1[1]), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("t6_rdy_release", 0, 32'(rdy0), 32'd0);
      step();
      chk("t6_rdy_first_edge", 0, 32'(rdy0), 32'd1);
      drive(1'b1, 16'h0077, 1'b0);
      step();
      drive(1'b0, 16'h0, 1'b0);
      chk("t6_next_vld", 0, 32'(vld0), 32'd1);
      chk("t6_next_sof", 0, 32'(sof0), 32'd1);
      chk("t6_next_data", 0, 32'(dat0[0]), 32'h0077);

      // Randomized traffic with occasional abort and reset
      rst_hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst = 1'b0;
         end else if ($urandom_range(0, 599) == 0) begin
            rst = 1'b1;
            rst_hold = $urandom_range(1, 3);
         end
         drive(($urandom_range(0, 9) < 8), 16'($urandom), ($urandom_range(0, 99) < 2));
         step();
      end
      rst = 1'b0;
      drive(1'b0, 16'h0, 1'b0);
      repeat (6) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/frame_feeder.md
FRAME_FEEDER -- requirements
Module: frame_feeder

Interface
REQ-001 SHALL have parameter NO_CH, default 16, bits per sample.
REQ-002 SHALL have parameter LOG2_IMG_SIZE, default 10, log2 of samples per frame.
REQ-003 SHALL have parameter THROUGHPUT, default 1, samples per output word; power of two, <= 2**LOG2_IMG_SIZE.
REQ-004 SHALL have parameter GAP_CYCLES, default 2, forced idle cycles after each frame; range 0..255.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port in_vld, input, 1, upstream sample valid.
REQ-008 SHALL have port in_data, input, NO_CH, upstream sample.
REQ-009 SHALL have port in_rdy, output, 1, sample accepted on a rising edge when in_vld && in_rdy.
REQ-010 SHALL have port frame_abort, input, 1, discard current frame.
REQ-011 SHALL have port vld_out, output, 1, data_out valid, one-cycle pulse per word; windower vld_in side.
REQ-012 SHALL have port data_out, output, unpacked [THROUGHPUT-1:0] of NO_CH bits, packed samples; windower data_in side.
REQ-013 SHALL have port sof_out, output, 1, qualifies first word of a frame.
REQ-014 SHALL have port eof_out, output, 1, qualifies last word of a frame.
REQ-015 SHALL have port frames_done, output, 16, completed-frame count, wraps at 2**16.

Function
REQ-016 SHALL implement states FILL and GAP; in_rdy = 1 in FILL, 0 in GAP, driven from a register.
REQ-017 SHALL stage accepted samples in lane order: the k-th accepted sample of a group goes to lane k, lane 0 earliest.
REQ-018 SHALL, on the edge accepting lane THROUGHPUT-1, load the staged group into data_out and set vld_out = 1 for exactly the next cycle (latency 1 cycle).
REQ-019 SHALL hold data_out unchanged while vld_out = 0; partial groups SHALL never appear on data_out.
REQ-020 SHALL count accepted samples in a LOG2_IMG_SIZE-bit index; sof_out = 1 with the word containing index 0, eof_out = 1 with the word containing index 2**LOG2_IMG_SIZE-1; both 0 whenever vld_out = 0.
REQ-021 SHALL, on the edge accepting index 2**LOG2_IMG_SIZE-1, wrap the index to 0, increment frames_done, and enter GAP (in_rdy = 0 from the next cycle).
REQ-022 SHALL remain in GAP for exactly GAP_CYCLES cycles, then return to FILL; with GAP_CYCLES = 0 it SHALL stay in FILL and accept back-to-back frames with no bubble.
REQ-023 SHALL, when frame_abort = 1 on an edge: discard staged lanes, reset the index to 0, leave frames_done unchanged, emit no vld_out for the partial group, and enter GAP (restart the gap count if already in GAP).
REQ-024 SHALL give frame_abort priority over a simultaneous accept; that sample is dropped, even if it would complete a group or frame.
REQ-025 SHALL ignore in_data whenever in_vld && in_rdy is 0; in_vld gaps mid-group or mid-frame SHALL only stall, never reset, progress.
REQ-026 SHALL produce exactly 2**LOG2_IMG_SIZE / THROUGHPUT vld_out pulses per non-aborted frame.

Reset
REQ-027 SHALL, while rst = 1, force in_rdy = 0, vld_out = 0, sof_out = 0, eof_out = 0, data_out = 0, frames_done = 0, staged lanes = 0, index = 0, state = FILL.
REQ-028 SHALL assert in_rdy = 1 on the first rising edge after rst deasserts; rst mid-frame SHALL discard all partial state without emitting vld_out.

Verification
REQ-029 SHALL verify THROUGHPUT=1, LOG2_IMG_SIZE=3, GAP_CYCLES=2 with in_vld held high and data 1..8 -> vld_out each following cycle, data_out 1..8, sof with 1, eof with 8, in_rdy low 2 cycles, frames_done=1.
REQ-030 SHALL verify THROUGHPUT=2, LOG2_IMG_SIZE=3 with data 1..8 -> 4 pulses, lanes {0:1,1:2},{3,4},{5,6},{7,8}; sof on first, eof on fourth.
REQ-031 SHALL verify THROUGHPUT=2 with in_vld toggling 1,0,1,0 -> data_out unchanged until the second accept, then a single pulse {A,B}.
REQ-032 SHALL verify frame_abort on the edge accepting sample 5 of 8 -> no pulse for sample 5, frames_done unchanged, in_rdy low 2 cycles, next accepted sample carries sof.
REQ-033 SHALL verify GAP_CYCLES=0 with two consecutive frames -> 16 consecutive vld_out pulses, in_rdy never low, frames_done=2.
REQ-034 SHALL verify rst asserted after 3 of 8 samples -> all outputs 0 immediately, no vld_out, and the next frame starts at index 0 with sof.
